// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receive framer.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Byte width of a received character
  localparam int DATA_W = 8;

  // Bit indices reported by the baud counter alongside its mid-bit strobe
  localparam logic [3:0] NUM_START      = 4'd0;
  localparam logic [3:0] NUM_FIRST_DATA = 4'd1;
  localparam logic [3:0] NUM_LAST_DATA  = 4'd8;
  localparam logic [3:0] NUM_STOP       = 4'd9;

  // Receive framer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    ABORT = 3'd4
  } state_e;

  // Plain-vector encodings of the states, for legacy tools and plain logic regs
  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_START = START;
  localparam logic [2:0] ST_DATA  = DATA;
  localparam logic [2:0] ST_STOP  = STOP;
  localparam logic [2:0] ST_ABORT = ABORT;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Multi-flop synchroniser for the asynchronous rx pin plus a
//                falling-edge detector on the synchronised line.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;

  // Shift the raw pin through the chain; reset to 1s so an idle line shows no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o = rx_prev_q & ~rx_s_o;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : UART receive framer. Detects the start edge, kicks the baud
//                counter, captures start/8 data/stop on the counter's mid-bit
//                strobes and presents the byte on a valid/ready handshake with
//                framing-error and overrun pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit STOP_CHECK  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              sel_data,
  input  logic [3:0]        num,
  output logic              en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  logic              rx_s;
  logic              fall;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              en_q, en_d;
  logic              busy_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              frame_err_q;
  logic              overrun_q;

  logic              deliver;
  logic              stop_bad;
  logic [2:0]        bit_idx;
  logic              data_num;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  // num 1..8 carries data bits d0..d7; map to a shift-register position
  assign bit_idx  = 3'(num - NUM_FIRST_DATA);
  assign data_num = (num >= NUM_FIRST_DATA) && (num <= NUM_LAST_DATA);

  // Next-state logic: frame sequencing, data capture and stop-bit evaluation
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    en_d     = 1'b0;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          en_d    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A line that is high again at the start-bit centre was only a glitch
        if (sel_data && (num == NUM_START)) begin
          state_d = rx_s ? ST_ABORT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sel_data && data_num) begin
          shift_d[bit_idx] = rx_s;
          if (num == NUM_LAST_DATA) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (sel_data && (num == NUM_STOP)) begin
          state_d  = ST_IDLE;
          stop_bad = ~rx_s;
          deliver  = rx_s | ~STOP_CHECK;
        end
      end
      ST_ABORT: begin
        // The baud counter cannot be cancelled, so sit out the rest of its frame
        if (sel_data && (num == NUM_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame state, shift register and start/busy flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      en_q    <= en_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Output holding register with valid/ready handshake and overrun protection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (deliver) begin
        if (rx_valid_q && !rx_ready) begin
          // Previous byte still held: keep it and drop the new one
          overrun_q <= 1'b1;
        end else begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign en        = en_q;
  assign busy      = busy_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame
//  Description : Bench for uart_rx_frame with a behavioural baud counter and
//                a serial-line driver. The baud period is shortened so the
//                whole run stays short.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_frame;

  localparam int BIT_CLK = 32;          // clocks per bit in this bench
  localparam int MID     = BIT_CLK / 2; // mid-bit strobe position

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       sel_data;
  logic [3:0] num;
  logic       en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int nchecks = 0;
  int nerrors = 0;

  uart_rx_frame #(
    .SYNC_STAGES (2),
    .STOP_CHECK  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .sel_data  (sel_data),
    .num       (num),
    .en        (en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  // Baud counter: started by en, strobes mid-bit for num 0..9, then releases
  logic run_q;
  int   cnt_q;
  always @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 0;
      num   <= 4'd0;
    end else if (!run_q) begin
      if (en) begin
        run_q <= 1'b1;
        cnt_q <= 0;
        num   <= 4'd0;
      end
    end else if (cnt_q == BIT_CLK - 1) begin
      cnt_q <= 0;
      if (num == 4'd9) begin
        run_q <= 1'b0;
        num   <= 4'd0;
      end else begin
        num <= num + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + 1;
    end
  end
  assign sel_data = run_q && (cnt_q == MID);

  // Event monitor: counts pulses, records timing and accepted bytes
  int         cyc = 0;
  int         en_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, valid_rise = 0;
  int         en_run = 0, en_max = 0, ferr_run = 0, ferr_max = 0;
  int         stop_cyc = 0, valid_cyc = 0, busy_fall_cyc = 0;
  logic       prev_valid = 1'b0, prev_busy = 1'b0, seen_num4 = 1'b0;
  logic [7:0] got_q[$];
  always @(posedge clk) begin
    cyc++;
    if (en) begin en_cnt++; en_run++; if (en_run > en_max) en_max = en_run; end
    else en_run = 0;
    if (frame_err) begin ferr_cnt++; ferr_run++; if (ferr_run > ferr_max) ferr_max = ferr_run; end
    else ferr_run = 0;
    if (overrun) ovr_cnt++;
    if (sel_data && num == 4'd9) stop_cyc = cyc;
    if (sel_data && num == 4'd4) seen_num4 = 1'b1;
    if (rx_valid && !prev_valid) begin valid_rise++; valid_cyc = cyc; end
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_valid = rx_valid;
    prev_busy  = busy;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  // Drive the first nbits of a frame (bit 0 = start) onto the line
  task automatic drive_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  // Full frame followed by one idle bit time so the counter can release
  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bits({stop, b, 1'b0}, 10);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++;
    if ({en, rx_data, rx_valid, frame_err, overrun, busy} !== 13'h0) begin
      nerrors++;
      $display("FAIL reset_state: got en=%b data=%h valid=%b ferr=%b ovr=%b busy=%b, expected all 0",
               en, rx_data, rx_valid, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    nchecks++;
    if ({en, rx_valid, busy} !== 3'b000) begin
      nerrors++;
      $display("FAIL idle_after_reset: got en=%b valid=%b busy=%b, expected 000", en, rx_valid, busy);
    end
  endtask

  task automatic test_basic();
    int e0 = en_cnt, f0 = ferr_cnt;
    got_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    nchecks++;
    if (en_cnt - e0 != 1 || en_max != 1) begin
      nerrors++;
      $display("FAIL basic_en: got %0d pulses (max width %0d), expected 1 of width 1", en_cnt - e0, en_max);
    end
    nchecks++;
    if (valid_cyc - stop_cyc != 1) begin
      nerrors++;
      $display("FAIL basic_latency: got %0d clk, expected 1", valid_cyc - stop_cyc);
    end
    nchecks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      nerrors++;
      $display("FAIL basic_data: got %0d bytes first=%h, expected 1 byte 55",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    nchecks++;
    if (ferr_cnt != f0 || busy_fall_cyc - stop_cyc != 1) begin
      nerrors++;
      $display("FAIL basic_err_busy: got ferr=%0d busy_fall_delay=%0d, expected 0 and 1",
               ferr_cnt - f0, busy_fall_cyc - stop_cyc);
    end
  endtask

  task automatic test_hold();
    int o0 = ovr_cnt;
    got_q.delete();
    rx_ready = 1'b0;
    send_byte(8'hA3, 1'b1);
    repeat (3) @(negedge clk);
    nchecks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3 || got_q.size() != 0) begin
      nerrors++;
      $display("FAIL hold: got valid=%b data=%h taken=%0d, expected valid=1 data=a3 taken=0",
               rx_valid, rx_data, got_q.size());
    end
    rx_ready = 1'b1;
    @(negedge clk);
    nchecks++;
    if (rx_valid !== 1'b0 || got_q.size() != 1 || ovr_cnt != o0) begin
      nerrors++;
      $display("FAIL hold_release: got valid=%b taken=%0d ovr=%0d, expected 0 1 0",
               rx_valid, got_q.size(), ovr_cnt - o0);
    end else if (got_q[0] !== 8'hA3) begin
      nchecks++;
      nerrors++;
      $display("FAIL hold_release_data: got %h, expected a3", got_q[0]);
    end
  endtask

  task automatic test_frame_err();
    int f0 = ferr_cnt, v0 = valid_rise;
    got_q.delete();
    rx_ready = 1'b1;
    ferr_max = 0;
    send_byte(8'h0F, 1'b0);
    nchecks++;
    if (ferr_cnt - f0 != 1 || ferr_max != 1) begin
      nerrors++;
      $display("FAIL frame_err_pulse: got %0d cycles (max run %0d), expected 1", ferr_cnt - f0, ferr_max);
    end
    nchecks++;
    if (valid_rise != v0 || got_q.size() != 0) begin
      nerrors++;
      $display("FAIL frame_err_drop: got %0d valids, expected 0", valid_rise - v0);
    end
  endtask

  task automatic test_glitch();
    int e0 = en_cnt, v0 = valid_rise;
    got_q.delete();
    rx_ready = 1'b1;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    nchecks++;
    if (busy !== 1'b1 || en_cnt - e0 != 1) begin
      nerrors++;
      $display("FAIL glitch_busy: got busy=%b en=%0d, expected busy=1 en=1", busy, en_cnt - e0);
    end
    repeat (8 * BIT_CLK) @(negedge clk);
    nchecks++;
    if (busy !== 1'b0 || valid_rise != v0 || busy_fall_cyc - stop_cyc != 1) begin
      nerrors++;
      $display("FAIL glitch_abort: got busy=%b valids=%0d busy_fall_delay=%0d, expected 0 0 1",
               busy, valid_rise - v0, busy_fall_cyc - stop_cyc);
    end
    send_byte(8'h3C, 1'b1);
    nchecks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      nerrors++;
      $display("FAIL glitch_next: got %0d bytes first=%h, expected 1 byte 3c",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int o0 = ovr_cnt;
    got_q.delete();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    nchecks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || ovr_cnt - o0 != 1) begin
      nerrors++;
      $display("FAIL overrun: got valid=%b data=%h ovr=%0d, expected 1 11 1",
               rx_valid, rx_data, ovr_cnt - o0);
    end
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    nchecks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h11 || rx_valid !== 1'b0) begin
      nerrors++;
      $display("FAIL overrun_drain: got %0d bytes first=%h valid=%b, expected 1 byte 11 valid 0",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'(($urandom_range(1, 254)));
    got_q.delete();
    rx_ready = 1'b1;
    seen_num4 = 1'b0;
    drive_bits({1'b1, b, 1'b0}, 6);
    nchecks++;
    if (seen_num4 !== 1'b1 || busy !== 1'b1) begin
      nerrors++;
      $display("FAIL reset_mid_setup: got num4=%b busy=%b, expected 1 1", seen_num4, busy);
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    nchecks++;
    if ({en, rx_data, rx_valid, frame_err, overrun, busy} !== 13'h0) begin
      nerrors++;
      $display("FAIL reset_mid_state: got en=%b data=%h valid=%b ferr=%b ovr=%b busy=%b, expected all 0",
               en, rx_data, rx_valid, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    got_q.delete();
    send_byte(8'hFF, 1'b1);
    nchecks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hFF) begin
      nerrors++;
      $display("FAIL reset_mid_next: got %0d bytes first=%h, expected 1 byte ff",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  // Random bytes and stop bits; a byte is delivered exactly when its stop bit is 1
  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         f0;
    rx_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      f0   = ferr_cnt;
      got_q.delete();
      send_byte(b, stop);
      nchecks++;
      if (stop) begin
        if (got_q.size() != 1 || got_q[0] !== b || ferr_cnt != f0) begin
          nerrors++;
          $display("FAIL random_%0d: got %0d bytes first=%h ferr=%0d, expected byte %h ferr 0",
                   n, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, ferr_cnt - f0, b);
        end
      end else begin
        if (got_q.size() != 0 || ferr_cnt - f0 != 1) begin
          nerrors++;
          $display("FAIL random_%0d: got %0d bytes ferr=%0d, expected 0 bytes ferr 1",
                   n, got_q.size(), ferr_cnt - f0);
        end
      end
    end
  endtask

  initial begin
    rx = 1'b1; rst = 1'b1; rx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
